rle_frame_packer: RTL and testbench

//  Sits directly downstream of the DCT -> hard-threshold -> RLE chain.

---
 rtl/rle_pkg.sv | 20 ++
 rtl/rle_pair_fifo.sv | 63 ++++++
 rtl/rle_frame_packer.sv | 173 +++++++++++++++++
 tb/tb_rle_frame_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE frame packer: field widths, header sync nibble
// and FSM state encoding.
package rle_pkg;

    localparam int VAL_W_DEF = 12;
    localparam int CNT_W_DEF = 8;
    localparam int WORD_W    = VAL_W_DEF + CNT_W_DEF;
    localparam int LEN_W     = 8;
    localparam int SEQ_W     = 8;

    localparam logic [3:0] SYNC_NIB = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

endpackage

// File: rtl/rle_pair_fifo.sv
// Synchronous FIFO with a write-side mark/rewind pair, so a partially written
// frame can be discarded by returning wr_ptr to the last committed boundary.
module rle_pair_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    input  logic         mark_i,
    input  logic         rewind_i
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q;
    logic [AW:0]  mark_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (rewind_i) begin
            wr_ptr_d = mark_q;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mark_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            // The mark is the first slot of the next frame.
            if (mark_i) begin
                mark_q <= wr_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/rle_frame_packer.sv
// Buffers RLE (value,count) pairs per block and emits header/payload/checksum
// words on a valid/ready stream. Optional checksum word: define CHECKSUM_EN.
module rle_frame_packer
    import rle_pkg::*;
#(
    parameter int VAL_W     = VAL_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEPTH     = 16,
    parameter int LEN_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [VAL_W-1:0]       in_value,
    input  logic [CNT_W-1:0]       in_count,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VAL_W+CNT_W-1:0] out_data,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [1:0]             dbg_state
);

    localparam int W = VAL_W + CNT_W;
`ifdef CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low, the
    // presented word (data/sof/eof) stays unchanged.

    logic             pair_full, pair_empty, len_full, len_empty;
    logic [W-1:0]     pair_dout;
    logic [LEN_W-1:0] len_dout;

    logic             ovf_now, pair_push, commit, rewind;
    logic             hs, frame_done, start_frame, pair_pop;
    logic [LEN_W-1:0] len_cnt_q;
    logic             drop_q, ovf_q;

    state_t           state_q;
    logic [LEN_W-1:0] rem_q;
    logic [SEQ_W-1:0] seq_q;
    logic [W-1:0]     csum_q;
    logic             out_valid_q, out_sof_q, out_eof_q;
    logic [W-1:0]     out_data_q;

    always_comb begin
        ovf_now   = in_valid && !drop_q && (pair_full || (in_last && len_full));
        pair_push = in_valid && !drop_q && !ovf_now;
        commit    = pair_push && in_last;
        rewind    = in_valid && in_last && (drop_q || ovf_now);

        hs          = out_valid_q && out_ready;
        // The output slot frees up when nothing is shown or the eof word leaves.
        frame_done  = (state_q == ST_IDLE) || (hs && out_eof_q);
        start_frame = frame_done && !len_empty;
        pair_pop    = hs && !pair_empty &&
                      ((state_q == ST_HDR) || (state_q == ST_PAY && rem_q != '0));
    end

    rle_pair_fifo #(.W(W), .DEPTH(DEPTH)) u_pair_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (pair_push),
        .din_i    ({in_count, in_value}),
        .pop_i    (pair_pop),
        .dout_o   (pair_dout),
        .full_o   (pair_full),
        .empty_o  (pair_empty),
        .mark_i   (commit),
        .rewind_i (rewind)
    );

    rle_pair_fifo #(.W(LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (commit),
        .din_i    (len_cnt_q + LEN_W'(1)),
        .pop_i    (start_frame),
        .dout_o   (len_dout),
        .full_o   (len_full),
        .empty_o  (len_empty),
        .mark_i   (1'b0),
        .rewind_i (1'b0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_cnt_q <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_now) begin
                ovf_q <= 1'b1;
            end
            if (in_valid && in_last) begin
                len_cnt_q <= '0;
                drop_q    <= 1'b0;
            end else begin
                if (pair_push) begin
                    len_cnt_q <= len_cnt_q + LEN_W'(1);
                end
                if (ovf_now) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            seq_q       <= '0;
            csum_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (start_frame) begin
            state_q     <= ST_HDR;
            rem_q       <= len_dout;
            csum_q      <= '0;
            out_valid_q <= 1'b1;
            out_sof_q   <= 1'b1;
            out_eof_q   <= 1'b0;
            out_data_q  <= W'({SYNC_NIB, seq_q, len_dout});
        end else if (frame_done) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (hs) begin
            case (state_q)
                ST_HDR, ST_PAY: begin
                    if (state_q == ST_HDR) begin
                        seq_q <= seq_q + SEQ_W'(1);
                    end
                    if (pair_pop) begin
                        state_q    <= ST_PAY;
                        rem_q      <= rem_q - LEN_W'(1);
                        csum_q     <= csum_q ^ pair_dout;
                        out_sof_q  <= 1'b0;
                        out_eof_q  <= !CSUM_ON && (rem_q == LEN_W'(1));
                        out_data_q <= pair_dout;
                    end else if (CSUM_ON) begin
                        state_q    <= ST_CSUM;
                        out_eof_q  <= 1'b1;
                        out_data_q <= csum_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rle_frame_packer.sv
// Directed bench for rle_frame_packer with a scoreboard queue of expected
// {sof,eof,data} words; expectations follow CHECKSUM_EN when it is defined.
module tb_rle_frame_packer;

`ifdef CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready, ovf_clr;
    logic [11:0] in_value;
    logic [7:0]  in_count;
    logic        out_valid, out_sof, out_eof, ovf;
    logic [19:0] out_data;
    logic [1:0]  dbg_state;

    logic [21:0] exp_q[$];
    logic [7:0]  seq_m;
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          check_nogap = 1'b0;
    bit          nogap_pend  = 1'b0;
    bit          stall_q     = 1'b0;
    logic [22:0] held;

    always #5 clk = ~clk;

    rle_frame_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: compare every accepted word, and hold/no-gap properties.
    always @(negedge clk) begin
        if (rst) begin
            stall_q    = 1'b0;
            nogap_pend = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold", {9'd0, out_valid, out_sof, out_eof, out_data}, {9'd0, held});
            end
            if (nogap_pend) begin
                check("nogap", {30'd0, out_valid, out_sof}, 32'd3);
                nogap_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_word: observed %h expected none", out_data);
                end
                if (exp_q.size() != 0) begin
                    check("word", {10'd0, out_sof, out_eof, out_data}, {10'd0, exp_q.pop_front()});
                end
                if (out_eof && check_nogap) begin
                    nogap_pend  = 1'b1;
                    check_nogap = 1'b0;
                end
            end
            stall_q = out_valid && !out_ready;
            held    = {out_valid, out_sof, out_eof, out_data};
        end
    end

    task automatic send_pair(input logic [11:0] v, input logic [7:0] c, input logic l);
        in_valid = 1'b1;
        in_value = v;
        in_count = c;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit drop);
        logic [19:0] w[$];
        logic [19:0] cs;
        logic [11:0] v;
        logic [7:0]  c;
        cs = '0;
        for (int i = 0; i < n; i++) begin
            v = 12'($urandom_range(0, 4095));
            c = 8'($urandom_range(0, 255));
            w.push_back({c, v});
            cs ^= {c, v};
        end
        if (!drop) begin
            exp_q.push_back({2'b10, 4'hA, seq_m, 8'(n)});
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, !CSUM_ON && (i == n-1), w[i]});
            end
            if (CSUM_ON) exp_q.push_back({2'b01, cs});
            seq_m++;
        end
        for (int i = 0; i < n; i++) begin
            send_pair(w[i][11:0], w[i][19:12], i == n-1);
        end
    endtask

    task automatic push_test1_words(input logic [7:0] seq);
        exp_q.push_back({2'b10, 4'hA, seq, 8'h03});
        exp_q.push_back({2'b00, 20'h02005});
        exp_q.push_back({2'b00, 20'h04000});
        exp_q.push_back({1'b0, !CSUM_ON, 20'h02FFD});
        if (CSUM_ON) exp_q.push_back({2'b01, 20'h04FF8});
    endtask

    task automatic send_test1_pairs();
        send_pair(12'h005, 8'h02, 1'b0);
        send_pair(12'h000, 8'h04, 1'b0);
        send_pair(12'hFFD, 8'h02, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        seq_m = 8'd0;
        check_nogap = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_value = '0; in_count = '0;
        out_ready = 1'b0; ovf_clr = 1'b0; seq_m = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eof", out_eof, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Test 1: known frame at full throughput.
        out_ready = 1'b1;
        push_test1_words(8'd0);
        seq_m = 8'd1;
        send_test1_pairs();
        wait_drain("t1_drain");

        // Test 2: same frame with a 3-cycle stall mid-payload.
        out_ready = 1'b0;
        push_test1_words(8'd1);
        seq_m = 8'd2;
        send_test1_pairs();
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("t2_drain");

        // Test 3: second frame overflows the pair FIFO and is discarded.
        do_reset();
        out_ready = 1'b0;
        send_frame(8, 1'b0);
        send_frame(9, 1'b1);
        check("t3_ovf_set", ovf, 1);
        out_ready = 1'b1;
        wait_drain("t3_drain");
        repeat (20) @(posedge clk);
        #1;
        check("t3_idle", out_valid, 0);
        check("t3_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("t3_ovf_clr", ovf, 0);

        // Test 4: back-to-back frames, eof followed directly by sof.
        do_reset();
        out_ready = 1'b1;
        check_nogap = 1'b1;
        send_frame(8, 1'b0);
        send_frame(8, 1'b0);
        wait_drain("t4_drain");

        // Test 5: reset mid-payload.
        do_reset();
        out_ready = 1'b0;
        send_frame(3, 1'b0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_state", dbg_state, 0);
        exp_q.delete();
        seq_m = 8'd0;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        send_frame(4, 1'b0);
        wait_drain("t5_drain");
        repeat (10) @(posedge clk);
        #1 check("t5_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
